// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: opcode decode plus boot/run/step/halt sequencing; define SEQ_PERF_CNT_EN to build the retired-instruction counter.
module ctrl_sequencer #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  output logic [5:0]       ctrlWord,
  input  logic             run_mode,
  input  logic             step_req,
  output logic             step_ack,
  input  logic             resume,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_cnt
);
  localparam int BW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam logic [5:0] STALL = 6'b100000;
  typedef enum logic [2:0] {BOOT, RUN, STEP_WAIT, STEP_EXEC, HALTED, SKIP} stateT;
  stateT state, nextState;
  logic [BW-1:0] bootCnt;
  logic isAlu, isHalt, isLegal, executing;
  logic [5:0] decoded;
  assign isAlu = opcode[5:4] == 2'b00 && opcode[3:1] != 3'b000;
  assign isHalt = opcode == 6'b111111;
  assign isLegal = isAlu || isHalt || opcode == 6'b000000 || opcode == 6'b010000 ||
                   opcode == 6'b010010 || opcode == 6'b100000 || opcode == 6'b100010;
  assign decoded = isAlu ? (opcode[0] ? 6'b001101 : 6'b010101) :
                   opcode == 6'b010000 ? 6'b001100 :
                   opcode == 6'b010010 ? 6'b000110 :
                   isHalt ? STALL : 6'b000000;
  assign state_o = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      bootCnt <= BW'(BOOT_CYCLES);
      illegal_o <= 1'b0;
    end else begin
      state <= nextState;
      if (state == BOOT && bootCnt != '0) bootCnt <= bootCnt - BW'(1);
      if (executing && !isLegal) illegal_o <= 1'b1;
    end
  // BOOT is left on the edge where the count would reach zero, so halt is held for BOOT_CYCLES cycles
  always_comb begin
    nextState = state;
    case (state)
      BOOT:      if (bootCnt <= BW'(1)) nextState = run_mode ? RUN : STEP_WAIT;
      RUN:       nextState = isHalt ? HALTED : run_mode ? RUN : STEP_WAIT;
      STEP_WAIT: nextState = run_mode ? RUN : step_req ? STEP_EXEC : STEP_WAIT;
      STEP_EXEC: nextState = isHalt ? HALTED : run_mode ? RUN : STEP_WAIT;
      HALTED:    if (resume) nextState = SKIP;
      SKIP:      nextState = run_mode ? RUN : STEP_WAIT;
      default:   nextState = BOOT;
    endcase
  end
  // SKIP runs HALT as a NOP so the PC steps past the instruction that stopped us
  always_comb begin
    executing = state == RUN || state == STEP_EXEC || state == SKIP;
    ctrlWord = !executing ? STALL : (state == SKIP && isHalt) ? 6'b000000 : decoded;
    step_ack = state == STEP_EXEC;
  end
`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retiredQ;
  logic retire;
  assign retire = executing && !ctrlWord[5];
  assign retired_cnt = retiredQ;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retiredQ <= '0;
    else if (retire && !(&retiredQ)) retiredQ <= retiredQ + CNT_W'(1);
`else
  assign retired_cnt = '0;
`endif
endmodule
